native_stream_out_port: RTL and testbench

Parametrised native video output port between the VDMA read FIFO and the timing generator. It issues FIFO read strobes from input timing and re-aligns syncs/DE to the FIFO's read latency so pixels leave on registered outputs. It emits frame, line and end-of-frame alignment pulses to the DMA read engine. It adds three things: reset-safe frame lock, per-line length checking, and FIFO underflow reporting.

---
 rtl/native_port_pkg.sv | 15 +
 rtl/sync_delay_line.sv | 29 ++
 rtl/native_stream_out_port.sv | 152 +++++++++++++++
 tb/tb_native_stream_out_port.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/native_port_pkg.sv
// Shared types and constants for the native video output port.
package native_port_pkg;

   typedef enum logic [1:0] {
      StLock,
      StActive,
      StDone
   } state_e;

   localparam string ModeOnce = "ONCE";
   localparam string ModeLine = "LINE";

   localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/sync_delay_line.sv
// Reset-clearable shift register; a depth of zero degenerates to a wire.
module sync_delay_line #(
   parameter int unsigned W     = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (DEPTH == 0) begin : g_wire
      assign q = d;
   end else begin : g_shift
      logic [W-1:0] stage_q [DEPTH];

      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
         end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/native_stream_out_port.sv
// Native video output port: FIFO read strobes, sync/DE re-alignment to the FIFO read latency,
// frame/line/end-of-frame alignment pulses, line length checking and underflow reporting.
module native_stream_out_port
   import native_port_pkg::*;
#(
   parameter int unsigned DSIZE  = 24,
   parameter string       MODE   = ModeOnce,
   parameter int unsigned RD_LAT = 1
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [15:0]      vactive,
   input  logic [15:0]      hactive,
   input  logic             in_vsync,
   input  logic             in_hsync,
   input  logic             in_de,
   input  logic [DSIZE-1:0] in_data,
   input  logic             fifo_empty,
   output logic             rd_en,
   output logic             out_vsync,
   output logic             out_hsync,
   output logic             out_de,
   output logic [DSIZE-1:0] odata,
   output logic             falign,
   output logic             lalign,
   output logic             ealign,
   output logic [15:0]      lcnt,
   output logic             line_err,
   output logic             underflow
);

   localparam int unsigned Lat      = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
   localparam bit          LineMode = (MODE == ModeLine);

   state_e state_q, state_d;

   logic             vs_r1_q, vs_r2_q, fall_vs_q;
   logic             de_r1_q, de_r2_q, line_end_q;
   logic             line_err_q, underflow_q;
   logic [15:0]      lcnt_q, pcnt_q, vact_q, hact_q;
   logic [2:0]       sync_in, sync_dly;
   logic             out_vs_q, out_hs_q, out_de_q;
   logic [DSIZE-1:0] odata_q;

   // Reads stay blocked after reset until a frame boundary is seen.
   assign rd_en = in_de && (state_q != StLock);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= StLock;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ealign  = 1'b0;
      unique case (state_q)
         StLock:   if (fall_vs_q) state_d = StActive;
         StActive: begin
            if (fall_vs_q) begin
               state_d = StActive;
            end else if (vact_q != 16'd0 && lcnt_q == vact_q) begin
               state_d = StDone;
               ealign  = 1'b1;
            end
         end
         StDone:   if (fall_vs_q) state_d = StActive;
         default:  state_d = StLock;
      endcase
   end

   // Falling-edge pulses are registered one cycle after the two-sample compare.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vs_r1_q    <= 1'b0;
         vs_r2_q    <= 1'b0;
         fall_vs_q  <= 1'b0;
         de_r1_q    <= 1'b0;
         de_r2_q    <= 1'b0;
         line_end_q <= 1'b0;
         line_err_q <= 1'b0;
      end else begin
         vs_r1_q    <= in_vsync;
         vs_r2_q    <= vs_r1_q;
         fall_vs_q  <= vs_r2_q & ~vs_r1_q;
         de_r1_q    <= in_de;
         de_r2_q    <= de_r1_q;
         line_end_q <= de_r2_q & ~de_r1_q;
         line_err_q <= (de_r2_q & ~de_r1_q) && (state_q != StLock) && (pcnt_q != hact_q);
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         lcnt_q      <= '0;
         pcnt_q      <= '0;
         vact_q      <= '0;
         hact_q      <= '0;
         underflow_q <= 1'b0;
      end else begin
         if (fall_vs_q) begin
            vact_q <= vactive;
            hact_q <= hactive;
         end
         if (fall_vs_q) begin
            lcnt_q <= '0;
         end else if (line_end_q && state_q == StActive) begin
            lcnt_q <= lcnt_q + 16'd1;
         end
         if (line_end_q) begin
            pcnt_q <= rd_en ? 16'd1 : 16'd0;
         end else if (rd_en && pcnt_q != 16'hFFFF) begin
            pcnt_q <= pcnt_q + 16'd1;
         end
         underflow_q <= (rd_en & fifo_empty) | (underflow_q & ~fall_vs_q);
      end
   end

   assign sync_in = {in_vsync, in_hsync, rd_en};

   sync_delay_line #(
      .W     (3),
      .DEPTH (Lat)
   ) u_sync_dly (
      .clock (clock),
      .rst_n (rst_n),
      .d     (sync_in),
      .q     (sync_dly)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         out_vs_q <= 1'b0;
         out_hs_q <= 1'b0;
         out_de_q <= 1'b0;
         odata_q  <= '0;
      end else begin
         {out_vs_q, out_hs_q, out_de_q} <= sync_dly;
         odata_q <= sync_dly[0] ? in_data : '0;
      end
   end

   assign out_vsync = out_vs_q;
   assign out_hsync = out_hs_q;
   assign out_de    = out_de_q;
   assign odata     = odata_q;
   assign falign    = fall_vs_q;
   assign lalign    = LineMode & line_end_q;
   assign lcnt      = lcnt_q;
   assign line_err  = line_err_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_native_stream_out_port.sv
// Directed bench: two ports (LINE and ONCE mode, read latency 2) share one stimulus stream.
module tb_native_stream_out_port;

   localparam logic [23:0] WordBase = 24'hA50000;

   logic        clock, rst_n;
   logic [15:0] vactive, hactive;
   logic        in_vsync, in_hsync, in_de, fifo_empty;
   logic [23:0] in_data;

   logic        rd_en_l, out_vsync_l, out_hsync_l, out_de_l, falign_l, lalign_l, ealign_l;
   logic        line_err_l, underflow_l;
   logic [23:0] odata_l;
   logic [15:0] lcnt_l;
   logic        rd_en_o, out_vsync_o, out_hsync_o, out_de_o, falign_o, lalign_o, ealign_o;
   logic        line_err_o, underflow_o;
   logic [23:0] odata_o;
   logic [15:0] lcnt_o;

   native_stream_out_port #(.DSIZE(24), .MODE("LINE"), .RD_LAT(2)) dut_line (
      .clock(clock), .rst_n(rst_n), .vactive(vactive), .hactive(hactive),
      .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de), .in_data(in_data),
      .fifo_empty(fifo_empty), .rd_en(rd_en_l), .out_vsync(out_vsync_l),
      .out_hsync(out_hsync_l), .out_de(out_de_l), .odata(odata_l), .falign(falign_l),
      .lalign(lalign_l), .ealign(ealign_l), .lcnt(lcnt_l), .line_err(line_err_l),
      .underflow(underflow_l)
   );

   native_stream_out_port #(.DSIZE(24), .MODE("ONCE"), .RD_LAT(2)) dut_once (
      .clock(clock), .rst_n(rst_n), .vactive(vactive), .hactive(hactive),
      .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de), .in_data(in_data),
      .fifo_empty(fifo_empty), .rd_en(rd_en_o), .out_vsync(out_vsync_o),
      .out_hsync(out_hsync_o), .out_de(out_de_o), .odata(odata_o), .falign(falign_o),
      .lalign(lalign_o), .ealign(ealign_o), .lcnt(lcnt_o), .line_err(line_err_o),
      .underflow(underflow_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0, n_pass = 0, edges = 0;
   int n_rd, n_lal_l, n_lal_o, n_eal_l, n_eal_o, n_err_l, n_err_o, n_err_coinc;
   int n_fal_l, n_fal_o, n_ohs, de_rise_at, out_rise_at, word_ptr;
   bit prev_lal, prev_in_de, prev_out_de;
   logic [23:0] pipe0, pipe1;
   logic [23:0] got_l[$], got_o[$];
   logic [15:0] lc_l[$], lc_o[$];

   task automatic clear_obs();
      n_rd = 0; n_lal_l = 0; n_lal_o = 0; n_eal_l = 0; n_eal_o = 0;
      n_err_l = 0; n_err_o = 0; n_err_coinc = 0; n_fal_l = 0; n_fal_o = 0; n_ohs = 0;
      de_rise_at = -1; out_rise_at = -1; word_ptr = 0;
      prev_lal = 1'b0; prev_in_de = in_de; prev_out_de = out_de_l;
      pipe0 = '0; pipe1 = '0;
      got_l.delete(); got_o.delete(); lc_l.delete(); lc_o.delete();
   endtask

   // One clock: drive inputs, step past the edge, model a 2-cycle FIFO, record outputs.
   task automatic cyc(input logic vs, input logic hs, input logic de, input logic emp);
      logic rd;
      in_vsync = vs; in_hsync = hs; in_de = de; fifo_empty = emp;
      #1;
      rd = rd_en_l;
      if (rd) n_rd++;
      if (de && !prev_in_de && de_rise_at < 0) de_rise_at = edges;
      prev_in_de = de;
      @(posedge clock);
      #1;
      edges++;
      pipe1 = pipe0;
      if (rd) begin
         pipe0 = WordBase + 24'(word_ptr);
         word_ptr++;
      end else begin
         pipe0 = '0;
      end
      in_data = pipe1;
      if (prev_lal) begin
         lc_l.push_back(lcnt_l);
         lc_o.push_back(lcnt_o);
      end
      prev_lal = lalign_l;
      if (lalign_l) n_lal_l++;
      if (lalign_o) n_lal_o++;
      if (ealign_l) n_eal_l++;
      if (ealign_o) n_eal_o++;
      if (falign_l) n_fal_l++;
      if (falign_o) n_fal_o++;
      if (out_hsync_l) n_ohs++;
      if (line_err_l) begin
         n_err_l++;
         if (lalign_l) n_err_coinc++;
      end
      if (line_err_o) n_err_o++;
      if (out_de_l) got_l.push_back(odata_l);
      if (out_de_o) got_o.push_back(odata_o);
      if (out_de_l && !prev_out_de && out_rise_at < 0) out_rise_at = edges;
      prev_out_de = out_de_l;
   endtask

   task automatic drive_line(input int n, input logic vs, input int emp_pix);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < n; p++) cyc(vs, 1'b0, 1'b1, p == emp_pix);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic vsync_pulse();
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_frame(input int npix[3], input int empty_line);
      clear_obs();
      vsync_pulse();
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      for (int l = 0; l < 3; l++) drive_line(npix[l], 1'b0, (l == empty_line) ? 1 : -1);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      in_de = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_checks++;
      if ({out_vsync_l, out_hsync_l, out_de_l, falign_l, lalign_l, ealign_l, line_err_l,
           underflow_l, rd_en_l} !== 9'b0)
         $display("FAIL reset_flags_line: got %b want 0", {out_vsync_l, out_hsync_l, out_de_l,
                  falign_l, lalign_l, ealign_l, line_err_l, underflow_l, rd_en_l});
      else n_pass++;
      n_checks++;
      if ({out_de_o, ealign_o, underflow_o, rd_en_o} !== 4'b0)
         $display("FAIL reset_flags_once: got %b want 0", {out_de_o, ealign_o, underflow_o, rd_en_o});
      else n_pass++;
      n_checks++;
      if (odata_l !== 24'd0 || lcnt_l !== 16'd0)
         $display("FAIL reset_data: got odata=%0h lcnt=%0d want 0/0", odata_l, lcnt_l);
      else n_pass++;
      rst_n = 1'b1;
      clear_obs();
      repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (n_rd !== 0) $display("FAIL lock_no_read: got %0d reads want 0", n_rd);
      else n_pass++;
   endtask

   task automatic test_line_frame();
      logic [23:0] g;
      run_frame('{4, 4, 4}, -1);
      n_checks++;
      if (out_rise_at - de_rise_at !== 3)
         $display("FAIL de_latency: got %0d want 3", out_rise_at - de_rise_at);
      else n_pass++;
      n_checks++;
      if (got_l.size() !== 12) $display("FAIL pixel_count: got %0d want 12", got_l.size());
      else n_pass++;
      for (int i = 0; i < 12; i++) begin
         g = (i < got_l.size()) ? got_l[i] : 24'hxxxxxx;
         n_checks++;
         if (g !== WordBase + 24'(i))
            $display("FAIL odata[%0d]: got %0h want %0h", i, g, WordBase + 24'(i));
         else n_pass++;
      end
      n_checks++;
      if (n_lal_l !== 3) $display("FAIL lalign_count: got %0d want 3", n_lal_l);
      else n_pass++;
      n_checks++;
      if (lc_l.size() !== 3) $display("FAIL lcnt_steps: got %0d want 3", lc_l.size());
      else n_pass++;
      for (int i = 0; i < lc_l.size() && i < 3; i++) begin
         n_checks++;
         if (lc_l[i] !== 16'(i + 1)) $display("FAIL lcnt_seq[%0d]: got %0d want %0d", i, lc_l[i], i + 1);
         else n_pass++;
      end
      n_checks++;
      if (n_eal_l !== 1) $display("FAIL ealign_line: got %0d want 1", n_eal_l);
      else n_pass++;
      n_checks++;
      if (n_err_l !== 0 || n_rd !== 12)
         $display("FAIL clean_frame: got err=%0d reads=%0d want 0/12", n_err_l, n_rd);
      else n_pass++;
   endtask

   task automatic test_reset_midline();
      clear_obs();
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (out_de_l !== 1'b1) $display("FAIL pre_reset_de: got %b want 1", out_de_l);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_de_l !== 1'b0 || odata_l !== 24'd0 || lcnt_l !== 16'd0)
         $display("FAIL async_clear: got de=%b odata=%0h lcnt=%0d want 0/0/0",
                  out_de_l, odata_l, lcnt_l);
      else n_pass++;
      repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
      clear_obs();
      repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (n_rd !== 0 || got_l.size() !== 0)
         $display("FAIL lock_gate: got reads=%0d out_de=%0d want 0/0", n_rd, got_l.size());
      else n_pass++;
      n_checks++;
      if (n_ohs !== 1) $display("FAIL hsync_in_lock: got %0d want 1", n_ohs);
      else n_pass++;
      run_frame('{4, 4, 4}, -1);
      n_checks++;
      if (n_rd !== 12 || got_l.size() !== 12)
         $display("FAIL relock_frame: got reads=%0d pixels=%0d want 12/12", n_rd, got_l.size());
      else n_pass++;
      n_checks++;
      if (got_l.size() != 12 || got_l[0] !== WordBase || got_l[11] !== WordBase + 24'd11)
         $display("FAIL relock_data: got first/last mismatch, size %0d want 12", got_l.size());
      else n_pass++;
      n_checks++;
      if (lcnt_l !== 16'd3 || n_eal_l !== 1)
         $display("FAIL relock_end: got lcnt=%0d ealign=%0d want 3/1", lcnt_l, n_eal_l);
      else n_pass++;
   endtask

   task automatic test_once();
      run_frame('{4, 4, 4}, -1);
      n_checks++;
      if (n_lal_o !== 0) $display("FAIL once_lalign: got %0d want 0", n_lal_o);
      else n_pass++;
      n_checks++;
      if (n_eal_o !== 1) $display("FAIL once_ealign: got %0d want 1", n_eal_o);
      else n_pass++;
      n_checks++;
      if (lc_o.size() !== 3 || lc_o[2] !== 16'd3)
         $display("FAIL once_lcnt_seq: got %0d steps want 3 ending at 3", lc_o.size());
      else n_pass++;
      n_checks++;
      if (got_o.size() !== 12 || n_fal_o !== 1)
         $display("FAIL once_frame: got pixels=%0d falign=%0d want 12/1", got_o.size(), n_fal_o);
      else n_pass++;
      repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (lcnt_o !== 16'd3) $display("FAIL once_lcnt_hold: got %0d want 3", lcnt_o);
      else n_pass++;
      vsync_pulse();
      n_checks++;
      if (lcnt_o !== 16'd0) $display("FAIL once_lcnt_clear: got %0d want 0", lcnt_o);
      else n_pass++;
   endtask

   task automatic test_line_err();
      run_frame('{4, 5, 4}, -1);
      n_checks++;
      if (n_err_l !== 1 || n_err_o !== 1)
         $display("FAIL line_err_count: got %0d/%0d want 1/1", n_err_l, n_err_o);
      else n_pass++;
      n_checks++;
      if (n_err_coinc !== 1) $display("FAIL line_err_align: got %0d want 1", n_err_coinc);
      else n_pass++;
      n_checks++;
      if (got_l.size() !== 13 || lcnt_l !== 16'd3)
         $display("FAIL long_line_frame: got pixels=%0d lcnt=%0d want 13/3", got_l.size(), lcnt_l);
      else n_pass++;
   endtask

   task automatic test_underflow();
      n_checks++;
      if (underflow_l !== 1'b0) $display("FAIL underflow_pre: got %b want 0", underflow_l);
      else n_pass++;
      run_frame('{4, 4, 4}, 1);
      n_checks++;
      if (underflow_l !== 1'b1 || underflow_o !== 1'b1)
         $display("FAIL underflow_set: got %b/%b want 1/1", underflow_l, underflow_o);
      else n_pass++;
      repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (underflow_l !== 1'b1) $display("FAIL underflow_hold: got %b want 1", underflow_l);
      else n_pass++;
      vsync_pulse();
      n_checks++;
      if (underflow_l !== 1'b0) $display("FAIL underflow_clear: got %b want 0", underflow_l);
      else n_pass++;
   endtask

   task automatic test_coincident();
      clear_obs();
      vsync_pulse();
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      drive_line(4, 1'b0, -1);
      drive_line(4, 1'b0, -1);
      drive_line(4, 1'b1, -1);
      n_checks++;
      if (lcnt_l !== 16'd0 || lcnt_o !== 16'd0)
         $display("FAIL coinc_lcnt: got %0d/%0d want 0/0", lcnt_l, lcnt_o);
      else n_pass++;
      n_checks++;
      if (n_fal_l !== 2 || n_eal_l !== 0 || n_eal_o !== 0)
         $display("FAIL coinc_pulses: got falign=%0d ealign=%0d/%0d want 2/0/0",
                  n_fal_l, n_eal_l, n_eal_o);
      else n_pass++;
      drive_line(4, 1'b0, -1);
      n_checks++;
      if (lcnt_l !== 16'd1 || n_eal_l !== 0 || n_err_l !== 0)
         $display("FAIL coinc_active: got lcnt=%0d ealign=%0d err=%0d want 1/0/0",
                  lcnt_l, n_eal_l, n_err_l);
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      vactive = 16'd3;
      hactive = 16'd4;
      in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; fifo_empty = 1'b0;
      in_data = '0;
      clear_obs();
      test_reset();
      test_line_frame();
      test_reset_midline();
      test_once();
      test_line_err();
      test_underflow();
      test_coincident();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
